// File: rtl/boomerang_pkg.sv
// Shared definitions for the boomerang LED sequence counters.
// Holds FSM state encodings and default LED/prescaler settings.
`timescale 1ns/1ps
package boomerang_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_COUNT = 2'd1,
        STATE_DONE  = 2'd2
    } state_e;

    localparam int         DEF_COUNT_WIDTH = 24;
    localparam int         DEF_TICK_DIV    = 1500000;
    localparam int         DEF_LED_COUNT   = 4;
    localparam logic [3:0] DEF_LEDS_BEGIN  = 4'b0000;
    localparam logic [3:0] DEF_LEDS_END    = 4'b1111;
    localparam logic [3:0] DEF_LEDS_STEP   = 4'b0001;

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Ports: clk, rst_n (async low), en (count enable, clears when low), tick.
`timescale 1ns/1ps
module tick_gen #(
    parameter int COUNT_WIDTH = 24,
    parameter int TICK_DIV    = 1500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(TICK_DIV - 1);

    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/count_back.sv
// Return leg of the boomerang: steps led down from LEDS_END to LEDS_BEGIN.
// Ports: clk, rst_n, go (level start), led, busy (COUNT), done (DONE).
`timescale 1ns/1ps
module count_back
    import boomerang_pkg::*;
#(
    parameter int                   COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int                   TICK_DIV    = DEF_TICK_DIV,
    parameter int                   LED_COUNT   = DEF_LED_COUNT,
    parameter logic [LED_COUNT-1:0] LEDS_BEGIN  = LED_COUNT'(DEF_LEDS_BEGIN),
    parameter logic [LED_COUNT-1:0] LEDS_END    = LED_COUNT'(DEF_LEDS_END),
    parameter logic [LED_COUNT-1:0] LEDS_STEP   = LED_COUNT'(DEF_LEDS_STEP)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    output logic [LED_COUNT-1:0] led,
    output logic                 busy,
    output logic                 done
);

    state_e               state_q;
    logic [LED_COUNT-1:0] led_q;
    logic [LED_COUNT-1:0] led_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 tick;

    tick_gen #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .TICK_DIV    (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == STATE_COUNT),
        .tick  (tick)
    );

    // Clamp at LEDS_BEGIN so the last step never wraps below it.
    always_comb begin
        led_d = led_q - LEDS_STEP;
        if ((led_q - LEDS_BEGIN) < LEDS_STEP) begin
            led_d = LEDS_BEGIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_IDLE;
            led_q   <= LEDS_END;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    led_q <= LEDS_END;
                    if (go) begin
                        state_q <= STATE_COUNT;
                        busy_q  <= 1'b1;
                    end
                end
                STATE_COUNT: begin
                    // go is ignored here; the sequence always completes.
                    if (tick) begin
                        if (led_q == LEDS_BEGIN) begin
                            state_q <= STATE_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            led_q <= led_d;
                        end
                    end
                end
                STATE_DONE: begin
                    led_q <= LEDS_BEGIN;
                    // Re-arm only once go has dropped.
                    if (!go) begin
                        state_q <= STATE_IDLE;
                        led_q   <= LEDS_END;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= STATE_IDLE;
                    led_q   <= LEDS_END;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_count_back.sv
// Directed bench for count_back over four parameter sets.
// Instances: nominal, clamp, END==BEGIN, and TICK_DIV=1.
`timescale 1ns/1ps
module tb_count_back;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go_v   [4];
    logic [3:0] led_w  [4];
    logic       busy_w [4];
    logic       done_w [4];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    count_back #(
        .COUNT_WIDTH (8), .TICK_DIV (4), .LED_COUNT (4),
        .LEDS_BEGIN (4'd0), .LEDS_END (4'd15), .LEDS_STEP (4'd1)
    ) u_nom (
        .clk (clk), .rst_n (rst_n), .go (go_v[0]),
        .led (led_w[0]), .busy (busy_w[0]), .done (done_w[0])
    );

    count_back #(
        .COUNT_WIDTH (8), .TICK_DIV (2), .LED_COUNT (4),
        .LEDS_BEGIN (4'd0), .LEDS_END (4'd10), .LEDS_STEP (4'd3)
    ) u_clamp (
        .clk (clk), .rst_n (rst_n), .go (go_v[1]),
        .led (led_w[1]), .busy (busy_w[1]), .done (done_w[1])
    );

    count_back #(
        .COUNT_WIDTH (8), .TICK_DIV (1), .LED_COUNT (4),
        .LEDS_BEGIN (4'd5), .LEDS_END (4'd5), .LEDS_STEP (4'd1)
    ) u_degen (
        .clk (clk), .rst_n (rst_n), .go (go_v[2]),
        .led (led_w[2]), .busy (busy_w[2]), .done (done_w[2])
    );

    count_back #(
        .COUNT_WIDTH (8), .TICK_DIV (1), .LED_COUNT (4),
        .LEDS_BEGIN (4'd0), .LEDS_END (4'd15), .LEDS_STEP (4'd1)
    ) u_fast (
        .clk (clk), .rst_n (rst_n), .go (go_v[3]),
        .led (led_w[3]), .busy (busy_w[3]), .done (done_w[3])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_run++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int id, input int e);
        chk($sformatf("idle led%0d", id), int'(led_w[id]), e);
        chk($sformatf("idle busy%0d", id), int'(busy_w[id]), 0);
        chk($sformatf("idle done%0d", id), int'(done_w[id]), 0);
    endtask

    // Raises go and checks every cycle after edge m (edge 0 = go sampled).
    // The k-th tick acts at edge k*t; done rises at edge (n+1)*t.
    // glitch: go drops after edge 0 and pulses once mid-count.
    task automatic run_seq(input int id, input int t, input int e,
                           input int b, input int s, input int ncyc,
                           input bit glitch);
        int n_tk;
        int d;
        int j;
        int el;
        int eb;
        int ed;
        n_tk = (e - b + s - 1) / s;
        d = (n_tk + 1) * t;
        go_v[id] = 1'b1;
        for (int m = 0; m < ncyc; m++) begin
            @(negedge clk);
            if (glitch && m == 0)  go_v[id] = 1'b0;
            if (glitch && m == 10) go_v[id] = 1'b1;
            if (glitch && m == 11) go_v[id] = 1'b0;
            if (glitch && m >= d + 1) begin
                el = e; eb = 0; ed = 0;
            end else if (m >= d) begin
                el = b; eb = 0; ed = 1;
            end else begin
                j = m / t;
                el = e - j * s;
                if (el < b) el = b;
                eb = 1; ed = 0;
            end
            chk($sformatf("seq%0d led m%0d", id, m), int'(led_w[id]), el);
            chk($sformatf("seq%0d busy m%0d", id, m), int'(busy_w[id]), eb);
            chk($sformatf("seq%0d done m%0d", id, m), int'(done_w[id]), ed);
        end
    endtask

    initial begin
        go_v[0] = 1'b0;
        go_v[1] = 1'b0;
        go_v[2] = 1'b0;
        go_v[3] = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle(0, 15);
        chk_idle(1, 10);
        chk_idle(2, 5);
        chk_idle(3, 15);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle(0, 15);

        // Nominal, go held high past done.
        run_seq(0, 4, 15, 0, 1, 70, 1'b0);
        go_v[0] = 1'b0;
        @(negedge clk);
        chk_idle(0, 15);

        // Re-arm with a one-cycle go and a mid-count go pulse.
        @(negedge clk);
        run_seq(0, 4, 15, 0, 1, 70, 1'b1);

        // Clamp: 10,7,4,1,0 then done.
        run_seq(1, 2, 10, 0, 3, 14, 1'b0);
        go_v[1] = 1'b0;
        @(negedge clk);
        chk_idle(1, 10);

        // END == BEGIN with TICK_DIV = 1.
        run_seq(2, 1, 5, 5, 1, 4, 1'b0);
        go_v[2] = 1'b0;
        @(negedge clk);
        chk_idle(2, 5);

        // TICK_DIV = 1 with default LEDs.
        run_seq(3, 1, 15, 0, 1, 20, 1'b0);
        go_v[3] = 1'b0;
        @(negedge clk);
        chk_idle(3, 15);

        // Async reset mid-count at led = 9.
        go_v[0] = 1'b1;
        @(negedge clk);
        go_v[0] = 1'b0;
        repeat (25) @(negedge clk);
        chk("pre-rst led", int'(led_w[0]), 9);
        chk("pre-rst busy", int'(busy_w[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async led", int'(led_w[0]), 15);
        chk("async busy", int'(busy_w[0]), 0);
        chk("async done", int'(done_w[0]), 0);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk_idle(0, 15);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
